// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: one-entry holding buffer per result source,
// round-robin grant of one buffered result per cycle onto a registered CDB.
`ifndef XLEN
`define XLEN 32
`endif

module cdb_arbiter #(
  parameter int NUM_REQ = 5,
  parameter int TAG_W   = 5,
  parameter int DATA_W  = `XLEN,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      squash,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*TAG_W-1:0]  req_tag,
  input  logic [NUM_REQ*DATA_W-1:0] req_value,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        pending,
  output logic                      cdb_valid,
  output logic [TAG_W-1:0]          cdb_tag,
  output logic [DATA_W-1:0]         cdb_value,
  output logic [IDX_W-1:0]          cdb_src
);

  typedef struct packed {
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] value;
  } ent_t;

  typedef struct packed {
    logic             vld;
    logic [IDX_W-1:0] src;
    ent_t             ent;
  } cdb_t;

  logic [NUM_REQ-1:0] pend;
  logic [NUM_REQ-1:0] gnt_oh;
  logic [NUM_REQ-1:0] acc;
  ent_t [NUM_REQ-1:0] ent;

  logic               gnt_vld;
  logic [IDX_W-1:0]   gnt_idx;
  logic [IDX_W:0]     scan;

  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  cdb_t               cdb_q, cdb_d;

  // Rotating priority search; scan is one bit wider so rr_ptr+k never overflows
  // before the modulo correction.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    scan    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan = {1'b0, rr_ptr_q} + (IDX_W+1)'(k);
      if (scan >= (IDX_W+1)'(NUM_REQ))
        scan = scan - (IDX_W+1)'(NUM_REQ);
      if (!gnt_vld && pend[scan[IDX_W-1:0]]) begin
        gnt_vld = 1'b1;
        gnt_idx = scan[IDX_W-1:0];
      end
    end
  end

  always_comb begin
    gnt_oh = '0;
    if (gnt_vld)
      gnt_oh[gnt_idx] = 1'b1;
  end

  // A granted slot frees up this cycle, so it can take a new result with no bubble.
  assign req_ready = {NUM_REQ{~squash}} & (~pend | gnt_oh);
  assign acc       = req_valid & req_ready;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_slot
    logic pend_q, pend_d;
    ent_t ent_q;

    always_comb begin
      pend_d = pend_q;
      if (squash)
        pend_d = 1'b0;
      else if (acc[i])
        pend_d = 1'b1;
      else if (gnt_oh[i])
        pend_d = 1'b0;
    end

    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        pend_q <= 1'b0;
        ent_q  <= '0;
      end else begin
        pend_q <= pend_d;
        if (acc[i])
          ent_q <= {req_tag[i*TAG_W +: TAG_W], req_value[i*DATA_W +: DATA_W]};
      end
    end

    assign pend[i] = pend_q;
    assign ent[i]  = ent_q;
  end

  always_comb begin
    cdb_d    = '0;
    rr_ptr_d = rr_ptr_q;
    if (!squash && gnt_vld) begin
      cdb_d.vld = 1'b1;
      cdb_d.src = gnt_idx;
      cdb_d.ent = ent[gnt_idx];
      rr_ptr_d  = (gnt_idx == IDX_W'(NUM_REQ-1)) ? '0 : gnt_idx + IDX_W'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cdb_q    <= '0;
      rr_ptr_q <= '0;
    end else begin
      cdb_q    <= cdb_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  assign pending   = pend;
  assign cdb_valid = cdb_q.vld;
  assign cdb_src   = cdb_q.src;
  assign cdb_tag   = cdb_q.ent.tag;
  assign cdb_value = cdb_q.ent.value;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: directed scenarios plus a randomized run against a
// queue-free behavioural model of buffers, round-robin pointer and CDB register.
module tb_cdb_arbiter;
  localparam int NUM_REQ = 5;
  localparam int TAG_W   = 5;
  localparam int DATA_W  = 32;
  localparam int IDX_W   = 3;

  logic                      clock, reset, squash;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*TAG_W-1:0]  req_tag;
  logic [NUM_REQ*DATA_W-1:0] req_value;
  logic [NUM_REQ-1:0]        req_ready, pending;
  logic                      cdb_valid;
  logic [TAG_W-1:0]          cdb_tag;
  logic [DATA_W-1:0]         cdb_value;
  logic [IDX_W-1:0]          cdb_src;

  int checks = 0;
  int errors = 0;

  cdb_arbiter #(.NUM_REQ(NUM_REQ), .TAG_W(TAG_W), .DATA_W(DATA_W), .IDX_W(IDX_W)) dut (
    .clock(clock), .reset(reset), .squash(squash),
    .req_valid(req_valid), .req_tag(req_tag), .req_value(req_value),
    .req_ready(req_ready), .pending(pending),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value), .cdb_src(cdb_src)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference model state
  bit                m_pend [NUM_REQ];
  logic [TAG_W-1:0]  m_tag  [NUM_REQ];
  logic [DATA_W-1:0] m_val  [NUM_REQ];
  int                m_rr;
  bit                m_cv;
  logic [TAG_W-1:0]  m_ct;
  logic [DATA_W-1:0] m_cval;
  int                m_cs;

  function automatic int m_grant();
    for (int k = 0; k < NUM_REQ; k++)
      if (m_pend[(m_rr + k) % NUM_REQ]) return (m_rr + k) % NUM_REQ;
    return -1;
  endfunction

  function automatic logic [NUM_REQ-1:0] m_ready();
    logic [NUM_REQ-1:0] r;
    int g;
    g = m_grant();
    for (int i = 0; i < NUM_REQ; i++) r[i] = !squash && (!m_pend[i] || i == g);
    return r;
  endfunction

  function automatic logic [NUM_REQ-1:0] m_pendv();
    logic [NUM_REQ-1:0] p;
    for (int i = 0; i < NUM_REQ; i++) p[i] = m_pend[i];
    return p;
  endfunction

  function automatic void m_reset();
    for (int i = 0; i < NUM_REQ; i++) begin
      m_pend[i] = 0; m_tag[i] = '0; m_val[i] = '0;
    end
    m_rr = 0; m_cv = 0; m_ct = '0; m_cval = '0; m_cs = 0;
  endfunction

  function automatic void m_edge();
    logic [NUM_REQ-1:0] rdy;
    int g;
    rdy = m_ready();
    g   = m_grant();
    m_cv = 0; m_ct = '0; m_cval = '0; m_cs = 0;
    if (squash) begin
      for (int i = 0; i < NUM_REQ; i++) m_pend[i] = 0;
    end else begin
      if (g >= 0) begin
        m_cv = 1; m_ct = m_tag[g]; m_cval = m_val[g]; m_cs = g;
        m_pend[g] = 0;
        m_rr = (g + 1) % NUM_REQ;
      end
      for (int i = 0; i < NUM_REQ; i++)
        if (req_valid[i] && rdy[i]) begin
          m_tag[i]  = req_tag[i*TAG_W +: TAG_W];
          m_val[i]  = req_value[i*DATA_W +: DATA_W];
          m_pend[i] = 1;
        end
    end
  endfunction

  task automatic tick();
    m_edge();
    @(posedge clock);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic [TAG_W-1:0] t,
                         input logic [DATA_W-1:0] d);
    req_valid[i] = v;
    req_tag[i*TAG_W +: TAG_W] = t;
    req_value[i*DATA_W +: DATA_W] = d;
  endtask

  task automatic clear_reqs();
    req_valid = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    m_reset();
    #2;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clock);
    #1;
    checks++;
    if (cdb_valid !== 1'b0 || cdb_tag !== '0 || cdb_value !== '0 || cdb_src !== '0) begin
      errors++;
      $display("FAIL reset_cdb: got v=%0b tag=%0d val=%h src=%0d, want all zero",
               cdb_valid, cdb_tag, cdb_value, cdb_src);
    end
    checks++;
    if (pending !== 5'b00000) begin
      errors++; $display("FAIL reset_pending: got %b want 00000", pending);
    end
    checks++;
    if (req_ready !== 5'b11111) begin
      errors++; $display("FAIL reset_ready: got %b want 11111", req_ready);
    end
    #2;
    reset = 1'b0;
  endtask

  task automatic test_single();
    set_req(2, 1'b1, TAG_W'(7), 32'hDEADBEEF);
    #1;
    checks++;
    if (req_ready !== 5'b11111) begin
      errors++; $display("FAIL single_ready: got %b want 11111", req_ready);
    end
    tick();
    clear_reqs();
    checks++;
    if (pending !== 5'b00100 || cdb_valid !== 1'b0) begin
      errors++; $display("FAIL single_pend: got pend=%b v=%0b want 00100/0", pending, cdb_valid);
    end
    tick();
    checks++;
    if (cdb_valid !== 1'b1 || cdb_tag !== TAG_W'(7) || cdb_value !== 32'hDEADBEEF ||
        cdb_src !== IDX_W'(2) || pending !== 5'b00000) begin
      errors++;
      $display("FAIL single_bcast: got v=%0b tag=%0d val=%h src=%0d pend=%b want 1/7/deadbeef/2/00000",
               cdb_valid, cdb_tag, cdb_value, cdb_src, pending);
    end
    tick();
    checks++;
    if (cdb_valid !== 1'b0 || cdb_tag !== '0 || cdb_value !== '0 || cdb_src !== '0) begin
      errors++;
      $display("FAIL single_idle: got v=%0b tag=%0d val=%h src=%0d want zeros",
               cdb_valid, cdb_tag, cdb_value, cdb_src);
    end
  endtask

  task automatic test_all_sources();
    do_reset();
    for (int i = 0; i < NUM_REQ; i++) set_req(i, 1'b1, TAG_W'(10 + i), DATA_W'(32'h1000 + i));
    tick();
    clear_reqs();
    checks++;
    if (pending !== 5'b11111) begin
      errors++; $display("FAIL all_pend: got %b want 11111", pending);
    end
    for (int k = 0; k < NUM_REQ; k++) begin
      tick();
      checks++;
      if (cdb_valid !== 1'b1 || cdb_src !== IDX_W'(k) || cdb_tag !== TAG_W'(10 + k) ||
          cdb_value !== DATA_W'(32'h1000 + k)) begin
        errors++;
        $display("FAIL all_seq%0d: got v=%0b src=%0d tag=%0d val=%h want 1/%0d/%0d/%h",
                 k, cdb_valid, cdb_src, cdb_tag, cdb_value, k, 10 + k, 32'h1000 + k);
      end
    end
    tick();
    checks++;
    if (cdb_valid !== 1'b0 || pending !== 5'b00000) begin
      errors++; $display("FAIL all_drain: got v=%0b pend=%b want 0/00000", cdb_valid, pending);
    end
    // pointer should be back at 0: source 0 beats source 4
    set_req(0, 1'b1, TAG_W'(1), 32'h11);
    set_req(4, 1'b1, TAG_W'(2), 32'h22);
    tick();
    clear_reqs();
    tick();
    checks++;
    if (cdb_valid !== 1'b1 || cdb_src !== IDX_W'(0) || cdb_tag !== TAG_W'(1)) begin
      errors++; $display("FAIL all_rr_wrap: got v=%0b src=%0d tag=%0d want 1/0/1", cdb_valid, cdb_src, cdb_tag);
    end
    tick();
    checks++;
    if (cdb_valid !== 1'b1 || cdb_src !== IDX_W'(4) || cdb_tag !== TAG_W'(2)) begin
      errors++; $display("FAIL all_rr_next: got v=%0b src=%0d tag=%0d want 1/4/2", cdb_valid, cdb_src, cdb_tag);
    end
  endtask

  task automatic test_fairness();
    int next0 = 1, exp0 = 1, last0 = 0, acc3 = -1, seen3 = 0;
    logic [NUM_REQ-1:0] r;
    logic a0, a3;
    set_req(0, 1'b1, TAG_W'(next0), DATA_W'(32'h100 + next0));
    set_req(3, 1'b1, TAG_W'(20), 32'h20);
    for (int cyc = 0; cyc < 14; cyc++) begin
      r = req_ready;
      checks++;
      if (r !== m_ready()) begin
        errors++; $display("FAIL fair_ready c%0d: got %b want %b", cyc, r, m_ready());
      end
      a0 = req_valid[0] & r[0];
      a3 = req_valid[3] & r[3];
      tick();
      if (a3) acc3 = cyc + 1;
      if (a0) last0 = next0;
      checks++;
      if (cdb_valid !== m_cv || cdb_tag !== m_ct || cdb_value !== m_cval || cdb_src !== IDX_W'(m_cs)) begin
        errors++;
        $display("FAIL fair_cdb c%0d: got v=%0b src=%0d tag=%0d want %0b/%0d/%0d",
                 cyc, cdb_valid, cdb_src, cdb_tag, m_cv, m_cs, m_ct);
      end
      if (cdb_valid === 1'b1 && cdb_src === IDX_W'(0)) begin
        checks++;
        if (cdb_tag !== TAG_W'(exp0)) begin
          errors++; $display("FAIL fair_src0_order: got tag %0d want %0d", cdb_tag, exp0);
        end
        exp0++;
      end
      if (cdb_valid === 1'b1 && cdb_src === IDX_W'(3)) begin
        seen3++;
        checks++;
        if (cdb_tag !== TAG_W'(20) || acc3 < 0 || (cyc + 1 - acc3) > NUM_REQ) begin
          errors++;
          $display("FAIL fair_src3_latency: got tag %0d wait %0d want tag 20 wait<=%0d",
                   cdb_tag, cyc + 1 - acc3, NUM_REQ);
        end
      end
      if (a0) begin
        if (cyc < 8) begin
          next0++;
          set_req(0, 1'b1, TAG_W'(next0), DATA_W'(32'h100 + next0));
        end else
          req_valid[0] = 1'b0;
      end
      if (a3) req_valid[3] = 1'b0;
      #1;
    end
    clear_reqs();
    checks++;
    if (seen3 !== 1) begin
      errors++; $display("FAIL fair_src3_once: got %0d broadcasts want 1", seen3);
    end
    checks++;
    if (exp0 !== last0 + 1) begin
      errors++; $display("FAIL fair_src0_noloss: got %0d broadcasts want %0d", exp0 - 1, last0);
    end
  endtask

  task automatic test_backpressure();
    int n9 = 0;
    do_reset();
    set_req(0, 1'b1, TAG_W'(5), 32'h5);
    set_req(1, 1'b1, TAG_W'(8), 32'h8);
    tick();
    clear_reqs();
    set_req(1, 1'b1, TAG_W'(9), 32'h9);
    #1;
    checks++;
    if (req_ready[1] !== 1'b0 || req_ready[0] !== 1'b1) begin
      errors++; $display("FAIL bp_ready_g0: got %b want rdy1=0 rdy0=1", req_ready);
    end
    tick();
    checks++;
    if (cdb_valid !== 1'b1 || cdb_src !== IDX_W'(0) || cdb_tag !== TAG_W'(5)) begin
      errors++; $display("FAIL bp_bcast0: got v=%0b src=%0d tag=%0d want 1/0/5", cdb_valid, cdb_src, cdb_tag);
    end
    checks++;
    if (req_ready[1] !== 1'b1) begin
      errors++; $display("FAIL bp_ready_g1: got %b want rdy1=1", req_ready);
    end
    tick();
    req_valid[1] = 1'b0;
    checks++;
    if (cdb_valid !== 1'b1 || cdb_src !== IDX_W'(1) || cdb_tag !== TAG_W'(8)) begin
      errors++; $display("FAIL bp_bcast1: got v=%0b src=%0d tag=%0d want 1/1/8", cdb_valid, cdb_src, cdb_tag);
    end
    for (int c = 0; c < 4; c++) begin
      tick();
      if (cdb_valid === 1'b1 && cdb_tag === TAG_W'(9)) n9++;
    end
    checks++;
    if (n9 !== 1) begin
      errors++; $display("FAIL bp_tag9_once: got %0d broadcasts want 1", n9);
    end
  endtask

  task automatic test_squash();
    int seen = 0;
    // pointer is now 2 (last grant was source 1)
    set_req(1, 1'b1, TAG_W'(21), 32'h21);
    set_req(2, 1'b1, TAG_W'(22), 32'h22);
    set_req(4, 1'b1, TAG_W'(24), 32'h24);
    tick();
    clear_reqs();
    squash = 1'b1;
    set_req(0, 1'b1, TAG_W'(30), 32'h30);
    #1;
    checks++;
    if (pending !== 5'b10110 || req_ready !== 5'b00000) begin
      errors++; $display("FAIL squash_ready: got pend=%b rdy=%b want 10110/00000", pending, req_ready);
    end
    tick();
    squash = 1'b0;
    clear_reqs();
    checks++;
    if (pending !== 5'b00000 || cdb_valid !== 1'b0 || cdb_tag !== '0 || cdb_value !== '0 || cdb_src !== '0) begin
      errors++;
      $display("FAIL squash_flush: got pend=%b v=%0b tag=%0d val=%h src=%0d want zeros",
               pending, cdb_valid, cdb_tag, cdb_value, cdb_src);
    end
    for (int c = 0; c < 6; c++) begin
      tick();
      if (cdb_valid !== 1'b0) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++; $display("FAIL squash_no_bcast: got %0d broadcasts want 0", seen);
    end
    set_req(1, 1'b1, TAG_W'(1), 32'h1);
    set_req(2, 1'b1, TAG_W'(2), 32'h2);
    tick();
    clear_reqs();
    tick();
    checks++;
    if (cdb_valid !== 1'b1 || cdb_src !== IDX_W'(2)) begin
      errors++; $display("FAIL squash_rr_hold: got v=%0b src=%0d want 1/2", cdb_valid, cdb_src);
    end
    tick();
    checks++;
    if (cdb_valid !== 1'b1 || cdb_src !== IDX_W'(1)) begin
      errors++; $display("FAIL squash_rr_next: got v=%0b src=%0d want 1/1", cdb_valid, cdb_src);
    end
  endtask

  task automatic test_mid_reset();
    for (int i = 0; i < 4; i++) set_req(i, 1'b1, TAG_W'(i + 1), DATA_W'(i + 1));
    tick();
    clear_reqs();
    tick();
    checks++;
    if (cdb_valid !== 1'b1 || cdb_src !== IDX_W'(2) || pending !== 5'b01011) begin
      errors++; $display("FAIL mreset_pre: got v=%0b src=%0d pend=%b want 1/2/01011", cdb_valid, cdb_src, pending);
    end
    #2;
    reset = 1'b1;
    m_reset();
    #1;
    checks++;
    if (pending !== '0 || cdb_valid !== 1'b0 || cdb_tag !== '0 || cdb_value !== '0 || cdb_src !== '0) begin
      errors++;
      $display("FAIL mreset_async: got pend=%b v=%0b tag=%0d val=%h src=%0d want zeros",
               pending, cdb_valid, cdb_tag, cdb_value, cdb_src);
    end
    reset = 1'b0;
    set_req(3, 1'b1, TAG_W'(3), 32'h3);
    set_req(0, 1'b1, TAG_W'(6), 32'h6);
    tick();
    clear_reqs();
    tick();
    checks++;
    if (cdb_valid !== 1'b1 || cdb_src !== IDX_W'(0) || cdb_tag !== TAG_W'(6)) begin
      errors++; $display("FAIL mreset_first: got v=%0b src=%0d tag=%0d want 1/0/6", cdb_valid, cdb_src, cdb_tag);
    end
    tick();
    checks++;
    if (cdb_valid !== 1'b1 || cdb_src !== IDX_W'(3) || cdb_tag !== TAG_W'(3)) begin
      errors++; $display("FAIL mreset_second: got v=%0b src=%0d tag=%0d want 1/3/3", cdb_valid, cdb_src, cdb_tag);
    end
  endtask

  task automatic test_random();
    logic [NUM_REQ-1:0] acc;
    for (int cyc = 0; cyc < 400; cyc++) begin
      squash = ($urandom_range(0, 19) == 0);
      for (int i = 0; i < NUM_REQ; i++)
        if (!req_valid[i] && $urandom_range(0, 2) == 0)
          set_req(i, 1'b1, TAG_W'($urandom), DATA_W'($urandom));
      #1;
      checks++;
      if (req_ready !== m_ready()) begin
        errors++; $display("FAIL rand_ready c%0d: got %b want %b", cyc, req_ready, m_ready());
      end
      acc = req_valid & req_ready;
      tick();
      checks++;
      if (cdb_valid !== m_cv || cdb_tag !== m_ct || cdb_value !== m_cval ||
          cdb_src !== IDX_W'(m_cs) || pending !== m_pendv()) begin
        errors++;
        $display("FAIL rand_cdb c%0d: got v=%0b src=%0d tag=%0d val=%h pend=%b want %0b/%0d/%0d/%h/%b",
                 cyc, cdb_valid, cdb_src, cdb_tag, cdb_value, pending, m_cv, m_cs, m_ct, m_cval, m_pendv());
      end
      req_valid = req_valid & ~acc;
    end
    squash = 1'b0;
    clear_reqs();
  endtask

  initial begin
    reset     = 1'b1;
    squash    = 1'b0;
    req_valid = '0;
    req_tag   = '0;
    req_value = '0;
    m_reset();
    test_reset();
    test_single();
    test_all_sources();
    test_fairness();
    test_backpressure();
    test_squash();
    test_mid_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Sequential arbiter that shares the single common data bus (CDB) among NUM_REQ functional-unit result sources (ALU, MULT0, MULT1, LOAD_STORE, BRANCH).
- Each source owns a one-entry holding buffer with a valid/ready handshake.
- Buffered results are granted round-robin, one per cycle, into a registered CDB output consumed by the RS, ROB and map table.
- Squash flushes all pending results on a branch mispredict.

Parameters:
- NUM_REQ, 5, number of result sources; index 0..NUM_REQ-1.
- TAG_W, 5, width of the ROB/physical-register tag.
- DATA_W, `XLEN (32), width of the result value.
- IDX_W, $clog2(NUM_REQ), width of the source index.

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- squash  input  1  mispredict flush; synchronous, sampled on the clock edge.
- req_valid  input  NUM_REQ  per-source result present.
- req_tag  input  NUM_REQ*TAG_W  per-source tag; source i occupies bits [i*TAG_W +: TAG_W].
- req_value  input  NUM_REQ*DATA_W  per-source value; source i occupies bits [i*DATA_W +: DATA_W].
- req_ready  output  NUM_REQ  source i's result is accepted at this edge when req_valid[i] & req_ready[i].
- pending  output  NUM_REQ  holding-buffer valid bits (registered).
- cdb_valid  output  1  registered broadcast valid.
- cdb_tag  output  TAG_W  registered broadcast tag.
- cdb_value  output  DATA_W  registered broadcast value.
- cdb_src  output  IDX_W  registered index of the broadcasting source.

Behaviour:
- Reset (asynchronous, any time including mid-operation):
  - All buffers are invalid; pending = 0.
  - cdb_valid = 0, cdb_tag = 0, cdb_value = 0, cdb_src = 0.
  - rr_ptr = 0.
- Arbitration (combinational, from registered state only):
  - Search pending starting at rr_ptr, ascending, wrapping modulo NUM_REQ.
  - The first set bit is the grant g. At most one grant per cycle.
- req_ready[i] = ~squash & (~pending[i] | grant[i]).
  - It depends only on state and squash, never on req_valid.
- Clock edge, squash = 0:
  - If a grant exists: cdb_valid <= 1; cdb_tag and cdb_value <= buffer g contents; cdb_src <= g; pending[g] cleared; rr_ptr <= (g+1) mod NUM_REQ.
  - If no grant: cdb_valid <= 0, cdb_tag <= 0, cdb_value <= 0, cdb_src <= 0; rr_ptr holds.
  - Accept: where req_valid[i] & req_ready[i], buffer i <= {req_tag[i], req_value[i]} and pending[i] <= 1.
  - Accept into the slot granted in the same cycle is legal. The old entry goes to the CDB and the new entry is stored, with no bubble.
- Clock edge, squash = 1:
  - All pending cleared; no accepts (req_ready = 0).
  - cdb_valid <= 0, cdb_tag <= 0, cdb_value <= 0, cdb_src <= 0.
  - rr_ptr holds.
  - A cdb_valid already high during the squash cycle stays visible for that cycle; the consumer handles it.
- Latency:
  - Result accepted at edge k is broadcast no earlier than the output registered at edge k+1.
  - Worst case is edge k+NUM_REQ, which bounds starvation at NUM_REQ-1 cycles of waiting.
- Each cdb_valid pulse lasts exactly one cycle per accepted result. Results are never duplicated or dropped except by squash or reset.
- A source holding req_valid with req_ready = 0 must keep req_tag and req_value stable.
- Buffer contents while pending = 0 are don't-care. The bench checks cdb_tag and cdb_value only when cdb_valid = 1, except that it checks zero after reset, squash and idle cycles.
- No combinational path from any req_* input to any output.

Test Plan:
- Reset asserted mid-stream with 3 results pending and cdb_valid = 1 -> immediately pending = 0, cdb_valid = 0, cdb_tag = 0, cdb_value = 0, cdb_src = 0. After release, the first grant starts from source 0.
- Single result: req_valid[2] = 1, tag 7, value 0xDEADBEEF, present for one cycle before edge 1 -> pending[2] = 1 after edge 1. After edge 2: cdb_valid = 1, tag 7, value 0xDEADBEEF, cdb_src = 2 for exactly one cycle, then cdb_valid = 0.
- All 5 sources accepted at the same edge, rr_ptr = 0, tags 10..14 -> cdb_src sequence 0,1,2,3,4 on 5 consecutive cycles with matching tags, then cdb_valid = 0 and rr_ptr back at 0.
- Fairness: source 0 offers a new result every cycle (tags 1,2,3,...), source 3 holds one result with tag 20 -> broadcasts alternate source 0, source 3 (tag 20), source 0,... Source 3 waits at most 4 cycles, and source 0 never loses a tag.
- Backpressure: sources 0 and 1 pending, rr_ptr = 0, source 1 presents tag 9 -> req_ready[1] = 0 in the grant-0 cycle and 1 in the grant-1 cycle. Tag 9 is broadcast exactly once, after the buffered source-1 result.
- Squash with sources 1, 2 and 4 pending and new req_valid[0] in the same cycle -> req_ready = 0. After the edge: pending = 0, cdb_valid = 0, none of those tags ever appear on the CDB, and rr_ptr is unchanged.
